pdp8_mem_resp: RTL and testbench

Parametrised, synthesizable multi-channel memory responder for PDP-8 unit and system benches. It replaces the fixed two-port (IFU + exec) memory model with N request channels, round-robin arbitration, and a configurable read latency. It sits behind the instruction-fetch, execution, and any DMA/checker masters, and serves one access per clock from a single-ported word array.

---
 rtl/pdp8_pkg.sv | 15 +
 rtl/pdp8_rr_arb.sv | 43 ++++
 rtl/pdp8_mem_resp.sv | 123 ++++++++++++
 tb/tb_pdp8_mem_resp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 bench definitions: memory request record and responder limits.
package pdp8_pkg;

  localparam int MEM_MAX_CH  = 8;
  localparam int MEM_MAX_LAT = 4;
  localparam int MEM_ADDR_W  = 12;
  localparam int MEM_DATA_W  = 12;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_s;

endpackage

// File: rtl/pdp8_rr_arb.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module pdp8_rr_arb
  import pdp8_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_id    = cand;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/pdp8_mem_resp.sv
// Multi-channel single-ported memory responder with RR arbitration and RD_LATENCY read pipeline.
// Optional per-channel access counters are built when PDP8_MEM_STATS_EN is defined.
module pdp8_mem_resp
  import pdp8_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 12,
  parameter int    DEPTH      = 4096,
  parameter int    NUM_CH     = 2,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    req,
  input  logic [NUM_CH-1:0]                    we,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    wdata,
  output logic [NUM_CH-1:0]                    gnt,
  output logic [NUM_CH-1:0]                    rd_valid,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    rd_data
`ifdef PDP8_MEM_STATS_EN
  ,
  output logic [NUM_CH-1:0][15:0]              rd_cnt,
  output logic [NUM_CH-1:0][15:0]              wr_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LAST  = RD_LATENCY - 1;

  // INIT_FILE names an image for benches to preload into mem hierarchically.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]         sel;
  logic                  acc;
  logic                  sel_we;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  addr_unused;

  pdp8_rr_arb #(.N(NUM_CH)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (sel)
  );

  assign acc         = |gnt;
  assign sel_we      = we[sel];
  assign sel_idx     = addr[sel][IDX_W-1:0];
  assign sel_wdata   = wdata[sel];
  assign addr_unused = ^addr;

  logic [RD_LATENCY-1:0] vld_p;
  logic [IW-1:0]         id_p  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_p [RD_LATENCY];
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] hold_q;

  // Stage 0: array access at the accept edge; later stages just delay data and id.
  always_ff @(posedge clk) begin
    if (acc && sel_we) begin
      mem[sel_idx] <= sel_wdata;
    end
    dat_p[0] <= mem[sel_idx];
    id_p[0]  <= sel;
    for (int s = 1; s < RD_LATENCY; s++) begin
      dat_p[s] <= dat_p[s-1];
      id_p[s]  <= id_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= acc && !sel_we;
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  // Output stage: last pipeline slot is routed to its channel and latched for holding.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (vld_p[LAST]) begin
      hold_q[id_p[LAST]] <= dat_p[LAST];
    end
  end

  always_comb begin
    rd_valid = '0;
    rd_data  = hold_q;
    if (vld_p[LAST]) begin
      rd_valid[id_p[LAST]] = 1'b1;
      rd_data[id_p[LAST]]  = dat_p[LAST];
    end
  end

`ifdef PDP8_MEM_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (acc) begin
      if (sel_we) begin
        wr_cnt[sel] <= sat_inc16(wr_cnt[sel]);
      end else begin
        rd_cnt[sel] <= sat_inc16(rd_cnt[sel]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pdp8_mem_resp.sv
// Directed bench for pdp8_mem_resp (3 channels, latency 3, 1K words) with a read scoreboard.
module tb_pdp8_mem_resp;

  localparam int LAT = 3;
  localparam int NCH = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      req, we, gnt, rd_valid;
  logic [NCH-1:0][11:0] addr, wdata, rd_data;
`ifdef PDP8_MEM_STATS_EN
  logic [NCH-1:0][15:0] rd_cnt, wr_cnt;
`endif

  pdp8_mem_resp #(
    .ADDR_WIDTH(12), .DATA_WIDTH(12), .DEPTH(1024), .NUM_CH(NCH), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef PDP8_MEM_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [11:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [11:0] model [1024];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: each expected read must appear exactly at its due cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      assert (rd_valid === (3'b001 << mon_e.ch)) else begin
        errors++;
        $error("FAIL rd_valid_ch%0d: got %b, expected %b", mon_e.ch, rd_valid, 3'b001 << mon_e.ch);
      end
      checks++;
      assert (rd_data[mon_e.ch] === mon_e.data) else begin
        errors++;
        $error("FAIL rd_data_ch%0d: got %o, expected %o", mon_e.ch, rd_data[mon_e.ch], mon_e.data);
      end
    end else if (rd_valid !== 3'b000) begin
      checks++;
      assert (rd_valid === 3'b000) else begin
        errors++;
        $error("FAIL unexpected_valid: got %b, expected 000", rd_valid);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic r, input logic w,
                        input logic [11:0] a, input logic [11:0] d);
    req[ch] = r; we[ch] = w; addr[ch] = a; wdata[ch] = d;
  endtask

  // Check the grant, record the expected effect of the access, advance one cycle.
  task automatic step(input logic [2:0] exp_g, input string tag);
    int ch;
    #1;
    check(tag, 64'(gnt), 64'(exp_g));
    ch = -1;
    for (int i = 0; i < NCH; i++) if (exp_g[i]) ch = i;
    if (ch >= 0) begin
      if (we[ch]) model[addr[ch][9:0]] = wdata[ch];
      else sbq.push_back('{ch, model[addr[ch][9:0]], cyc + LAT});
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    req   = '0;
    sbq.delete();
    repeat (2) @(negedge clk);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL %s: %0d reads pending, expected 0", tag, sbq.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_gnt_idle", 64'(gnt), 64'd0);
    req = 3'b110;
    #1;
    check("reset_gnt_follows_req", 64'(gnt), 64'b010);
    req = '0;
    @(negedge clk);
    reset = 1'b0;

    // Reset while a read is in flight: it must never respond.
    set_ch(0, 1'b1, 1'b0, 12'o0200, 12'o0);
    step(3'b001, "rst_mid_read_gnt");
    do_reset("rst_mid_read");
    repeat (6) @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 12'o0777, 12'o0001);
    set_ch(1, 1'b1, 1'b1, 12'o0776, 12'o0002);
    set_ch(2, 1'b1, 1'b1, 12'o0775, 12'o0003);
    step(3'b001, "rr_ptr_after_reset");
    req = '0;

    // Write then read on channel 1.
    set_ch(1, 1'b1, 1'b1, 12'o0040, 12'o7402);
    step(3'b010, "wr_ch1_gnt");
    set_ch(1, 1'b1, 1'b0, 12'o0040, 12'o0);
    step(3'b010, "rd_ch1_gnt");
    req = '0;
    drain("wr_rd_drain");
    check("wr_rd_held_data", 64'(rd_data[1]), 64'(12'o7402));

    // Addresses alias modulo DEPTH.
    set_ch(2, 1'b1, 1'b1, 12'o2005, 12'o1234);
    step(3'b100, "alias_wr_gnt");
    set_ch(2, 1'b1, 1'b0, 12'o0005, 12'o0);
    step(3'b100, "alias_rd_gnt");
    req = '0;
    drain("alias_drain");
    check("alias_data", 64'(rd_data[2]), 64'(12'o1234));

    // Back-to-back reads on one channel fill the pipeline.
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 1'b1, 12'(12'o0010 + i), 12'(12'o5000 + i));
      step(3'b001, "pipe_wr_gnt");
    end
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 1'b0, 12'(12'o0010 + i), 12'o0);
      step(3'b001, "pipe_rd_gnt");
    end
    req = '0;
    drain("pipe_drain");
    check("pipe_last_data", 64'(rd_data[0]), 64'(12'o5003));

    // Three-way contention after reset: strict 0,1,2 rotation.
    for (int i = 0; i < 6; i++) begin
      set_ch(0, 1'b1, 1'b1, 12'(12'o0100 + i), 12'(12'o3000 + i));
      step(3'b001, "cont_preload_gnt");
    end
    req = '0;
    do_reset("cont_reset");
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 1'b0, 12'(12'o0100 + c), 12'o0);
    for (int t = 0; t < 6; t++) begin
      step(3'b001 << (t % 3), "cont_gnt");
      addr[t % 3] = addr[t % 3] + 12'd3;
    end
    req = '0;
    drain("cont_drain");
    check("cont_ch0_held", 64'(rd_data[0]), 64'(12'o3003));
    check("cont_ch2_held", 64'(rd_data[2]), 64'(12'o3005));

`ifdef PDP8_MEM_STATS_EN
    do_reset("stats_reset");
    for (int i = 0; i < 5; i++) begin
      set_ch(0, 1'b1, 1'b0, 12'(12'o0100 + i), 12'o0);
      step(3'b001, "stats_rd_gnt");
    end
    for (int i = 0; i < 2; i++) begin
      set_ch(0, 1'b1, 1'b1, 12'(12'o0300 + i), 12'(12'o0042 + i));
      step(3'b001, "stats_wr_gnt");
    end
    req = '0;
    drain("stats_drain");
    check("stats_rd_cnt0", 64'(rd_cnt[0]), 64'd5);
    check("stats_wr_cnt0", 64'(wr_cnt[0]), 64'd2);
    check("stats_rd_cnt1", 64'(rd_cnt[1]), 64'd0);
    do_reset("stats_clear");
    check("stats_rd_cnt0_clr", 64'(rd_cnt[0]), 64'd0);
    check("stats_wr_cnt0_clr", 64'(wr_cnt[0]), 64'd0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
